// File: rtl/fifo_out_deskew.sv
// Realigns the skewed lane outputs of the systolic array into rows, requantises each lane
// to int8, and buffers the packed rows in a small FIFO that is read one 32-bit word at a time.
module fifo_out_deskew #(
   parameter int N     = 16,
   parameter int ACC_W = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             shift_en,
   input  logic             in_valid,
   input  logic [N*ACC_W-1:0] in_sums,
   input  logic [4:0]       rq_shift,
   input  logic [1:0]       command,
   input  logic [1:0]       col,
   output logic [31:0]      output0,
   output logic             rd_valid,
   output logic             fifo_empty,
   output logic             fifo_full,
   output logic             overflow,
   output logic             underflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
   localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

   logic [ACC_W-1:0] aligned [N];
   logic [N-2:0]     vchain;
   logic [N*8-1:0]   wdata;
   logic [N*8-1:0]   mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             flush, rd_cmd, empty, full;
   logic             push_req, push_ok, push_drop, pop;
   logic [31:0]      head_word;

   // Lane j is delayed by N-1-j shift edges so every lane of a row lines up with lane N-1.
   for (genvar j = 0; j < N-1; j++) begin : g_lane
      logic [ACC_W-1:0] sr [N-1-j];
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            for (int k = 0; k < N-1-j; k++) sr[k] <= '0;
         end else if (shift_en) begin
            sr[0] <= in_sums[j*ACC_W +: ACC_W];
            for (int k = 1; k < N-1-j; k++) sr[k] <= sr[k-1];
         end
      end
      assign aligned[j] = sr[N-2-j];
   end
   assign aligned[N-1] = in_sums[(N-1)*ACC_W +: ACC_W];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)       vchain <= '0;
      else if (flush)    vchain <= '0;
      else if (shift_en) vchain <= {vchain[N-3:0], in_valid};
   end

   // Round-half-up shift in one extra bit so the rounding add cannot wrap, then saturate.
   function automatic logic [7:0] requant(input logic [ACC_W-1:0] x, input logic [4:0] sh);
      logic signed [ACC_W:0] xe, rnd, r;
      xe  = {x[ACC_W-1], x};
      rnd = '0;
      if (sh != 5'd0) rnd = (ACC_W+1)'(1) << (sh - 5'd1);
      r = (xe + rnd) >>> sh;
      if (r > SAT_HI)      return 8'h7f;
      else if (r < SAT_LO) return 8'h80;
      else                 return r[7:0];
   endfunction

   always_comb begin
      wdata = '0;
      for (int j = 0; j < N; j++) wdata[j*8 +: 8] = requant(aligned[j], rq_shift);
   end

   assign flush     = (command == 2'b00) && (col == 2'b11);
   assign rd_cmd    = (command == 2'b11);
   assign empty     = (count == '0);
   assign full      = (count == (AW+1)'(DEPTH));
   assign pop       = rd_cmd && !empty && (col == 2'b11);
   assign push_req  = shift_en && vchain[N-2] && !flush;
   assign push_ok   = push_req && (!full || pop);
   assign push_drop = push_req && full && !pop;
   assign head_word = mem[rd_ptr][{col, 5'b00000} +: 32];

   assign fifo_empty = empty;
   assign fifo_full  = full;

   // Read handshake: rd_valid is high for one cycle after each successful read command;
   // output0 keeps the last read word until the next read or reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         rd_valid  <= 1'b0;
         output0   <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         if (rd_cmd) begin
            if (!empty) begin
               output0  <= head_word;
               rd_valid <= 1'b1;
            end else begin
               output0   <= '0;
               underflow <= 1'b1;
            end
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push_ok) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (push_drop) overflow <= 1'b1;
         if (push_ok && !pop)      count <= count + 1'b1;
         else if (pop && !push_ok) count <= count - 1'b1;
      end
   end

endmodule
